tcm_ctrl: RTL and testbench
===========================

// Module: tcm_ctrl
// PURPOSE
//  Two-requester controller for one single-port TCM (sim_ram, 1-cycle read latency, addr_r held while we=0).
//  Arbitrates LSU (high priority) and EXT/debug port (starvation-protected) onto the RAM.
//  Converts byte addresses to word indices, range/alignment-checks, and returns one response per accepted cmd.
//  Sits between core LSU / system bus slave and the DTCM (or ITCM loader path).
// PARAMETERS
//  DP         512        RAM depth in words
//  DW         32         data width
//  MW         4          write-mask width (bytes)
//  AW         32         requester byte-address width
//  RAW        $clog2(DP) RAM word-address width
//  BASE_ADDR  32'h0      byte base address of the TCM window
//  STARVE_MAX 4          max consecutive LSU grants while EXT waits
// PORTS
//  clk             in   1    clock, all logic posedge
//  rst_n           in   1    synchronous active-low reset
//  lsu_cmd_valid   in   1    LSU command valid; same set for ext_* (EXT requester)
//  lsu_cmd_ready   out  1    command accepted when valid&ready
//  lsu_cmd_read    in   1    1=read, 0=write
//  lsu_cmd_addr    in   AW   byte address
//  lsu_cmd_wdata   in   DW   write data
//  lsu_cmd_wmask   in   MW   byte write enables
//  lsu_rsp_valid   out  1    response valid
//  lsu_rsp_ready   in   1    response accepted when valid&ready
//  lsu_rsp_rdata   out  DW   read data (0 for writes/errors)
//  lsu_rsp_err     out  1    out-of-window or misaligned access
//  ram_addr        out  RAW  to sim_ram addr
//  ram_din         out  DW   to sim_ram din
//  ram_we          out  1    to sim_ram we
//  ram_wem         out  MW   to sim_ram wem
//  ram_dout        in   DW   from sim_ram dout
// BEHAVIOUR
//  - Reset: all cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_we=0, ram_wem=0, ram_addr=0, starve cnt=0.
//  - States: IDLE (no rsp pending) / PEND_L / PEND_E (rsp pending to that requester).
//  - Issue allowed when IDLE, or PEND_x with x_rsp_ready=1 this cycle (back-to-back, 1 cmd/cycle).
//  - Arbitration when issue allowed: LSU wins unless starve_cnt==STARVE_MAX and ext_cmd_valid; then EXT wins.
//  - starve_cnt: +1 on LSU grant while ext_cmd_valid (saturating at STARVE_MAX); clears on EXT grant or !ext_cmd_valid.
//  - cmd_ready is combinational: asserted only to the granted requester; never both.
//  - Accept cycle N: word idx = (addr-BASE_ADDR)>>2; write drives ram_we=1, ram_wem=wmask, ram_din=wdata.
//  - Error if addr<BASE_ADDR, addr>=BASE_ADDR+4*DP, or addr[1:0]!=0: no RAM write (ram_we=0), rsp_err=1.
//  - Response valid cycle N+1 to the issuing requester only; read rdata = ram_dout; write/err rdata=0.
//  - While rsp pending and not accepted: ram_we=0, ram_addr held at last read idx -> ram_dout stable; no new cmd.
//  - No grant: ram_we=0, ram_wem=0, ram_addr holds previous value.
//  - Write followed by read of same word: read returns newly written bytes (RAM writes at N, reads at N+1).
//  - Simultaneous rsp accept and new cmd: old rsp retires, new rsp valid next cycle, no bubble.
//  - Reset mid-operation: pending rsp dropped, no rsp_valid after reset; RAM contents untouched.
// STRUCTURE
//  - tcm_defines.vh: REQ_LSU/REQ_EXT ids, state encodings, BASE/limit helper macros.
//  - Sub-module tcm_arb: 2-way priority arbiter + starvation counter (inputs valids, issue_en; outputs grant).
//  - tcm_ctrl: address decode/check, state + rsp registers, RAM drive mux.
// TESTING
//  - Reset: assert rst_n=0 with cmd pending -> all outputs 0, next cycle after release idle, no rsp.
//  - LSU write 0x0000_0010 wdata 0xDEADBEEF wmask 4'b1111, then read 0x10 -> rsp rdata 0xDEADBEEF, err 0, at N+1.
//  - Byte mask: write 0x55667788 mask 4'b0010 to word 0x10 -> read returns 0xDEAD77EF.
//  - Error: read 0x0000_0802 (DP=512) and 0x0000_0011 -> rsp_err=1, rdata 0, ram_we never 1.
//  - Starvation: LSU+EXT valid continuously -> grants L,L,L,L,E,L,L,L,L,E...; EXT never waits >5 cycles.
//  - Backpressure: lsu_rsp_ready=0 for 3 cycles on read of 0x10 -> rdata stays 0xDEAD77EF, cmd_ready=0 throughout.

Source files
------------

// File: rtl/tcm_ctrl_pkg.sv
// Shared types and helpers for the TCM controller: FSM state encoding,
// requester identifiers and the word-alignment test.
package tcm_ctrl_pkg;

    // Controller state: idle, or a response owed to one of the requesters
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND_L = 2'd1,
        ST_PEND_E = 2'd2
    } state_t;

    // Which requester drives the RAM in the current cycle
    typedef enum logic [0:0] {
        REQ_LSU = 1'b0,
        REQ_EXT = 1'b1
    } req_t;

    // A byte address is usable only when it points at a whole word
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/tcm_ctrl_if.sv
// One requester port of the TCM controller: command channel plus
// response channel, each with its own valid/ready handshake.
interface tcm_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tcm_ctrl_arb.sv
// Two-way arbiter: LSU has priority, but once the LSU has been granted
// STARVE_MAX times in a row while EXT was waiting, EXT gets the next slot.
module tcm_ctrl_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lsu_valid,
    input  logic ext_valid,
    input  logic issue_en,
    output logic gnt_lsu,
    output logic gnt_ext
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          ext_first;

    // Grant decision; at most one grant, and only when a slot is free
    always_comb begin
        ext_first = ext_valid && (!lsu_valid || (starve_cnt == CW'(STARVE_MAX)));
        gnt_ext   = issue_en && ext_first;
        gnt_lsu   = issue_en && lsu_valid && !ext_first;
    end

    // Count LSU wins while EXT is kept waiting, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (gnt_ext || !ext_valid) begin
            starve_cnt <= '0;
        end else if (gnt_lsu && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/tcm_ctrl.sv
// Controller for one single-port TCM shared by the LSU and an external
// (debug / system bus) requester. Decodes byte addresses into word
// indices, rejects out-of-window or misaligned accesses, and returns
// exactly one response per accepted command, one cycle after acceptance.
module tcm_ctrl
    import tcm_ctrl_pkg::*;
#(
    parameter int            DP         = 512,
    parameter int            DW         = 32,
    parameter int            MW         = 4,
    parameter int            AW         = 32,
    parameter int            RAW        = $clog2(DP),
    parameter logic [AW-1:0] BASE_ADDR  = '0,
    parameter int            STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    tcm_ctrl_if.slave      lsu,
    tcm_ctrl_if.slave      ext,
    output logic [RAW-1:0] ram_addr,
    output logic [DW-1:0]  ram_din,
    output logic           ram_we,
    output logic [MW-1:0]  ram_wem,
    input  logic [DW-1:0]  ram_dout
);
    // One past the last byte of the window, one bit wider so it cannot wrap
    localparam logic [AW:0] LIMIT = {1'b0, BASE_ADDR} + (AW+1)'(4 * DP);

    state_t         state, state_nxt;
    logic           issue_en;
    logic           gnt_lsu, gnt_ext, gnt_any;
    req_t           sel;
    logic           sel_read;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [MW-1:0]  sel_wmask;
    logic           sel_ok;
    logic [RAW-1:0] sel_idx;
    logic [RAW-1:0] addr_q;
    logic           rd_q;
    logic           err_q;

    function automatic logic in_window(input logic [AW-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT) && is_word_aligned(a[1:0]);
    endfunction

    function automatic logic [RAW-1:0] word_idx(input logic [AW-1:0] a);
        return RAW'((a - BASE_ADDR) >> 2);
    endfunction

    // A new command may issue when nothing is owed, or the owed response retires now
    always_comb begin
        issue_en = 1'b0;
        if (rst_n) begin
            unique case (state)
                ST_IDLE:   issue_en = 1'b1;
                ST_PEND_L: issue_en = lsu.rsp_ready;
                ST_PEND_E: issue_en = ext.rsp_ready;
                default:   issue_en = 1'b0;
            endcase
        end
    end

    tcm_ctrl_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_valid (lsu.cmd_valid),
        .ext_valid (ext.cmd_valid),
        .issue_en  (issue_en),
        .gnt_lsu   (gnt_lsu),
        .gnt_ext   (gnt_ext)
    );

    // Select the granted command and decode its address
    always_comb begin
        gnt_any = gnt_lsu || gnt_ext;
        sel     = gnt_ext ? REQ_EXT : REQ_LSU;
        if (sel == REQ_EXT) begin
            sel_read  = ext.cmd_read;
            sel_addr  = ext.cmd_addr;
            sel_wdata = ext.cmd_wdata;
            sel_wmask = ext.cmd_wmask;
        end else begin
            sel_read  = lsu.cmd_read;
            sel_addr  = lsu.cmd_addr;
            sel_wdata = lsu.cmd_wdata;
            sel_wmask = lsu.cmd_wmask;
        end
        sel_ok  = in_window(sel_addr);
        sel_idx = word_idx(sel_addr);
    end

    // RAM drive: address holds when idle so a pending read keeps its data stable
    always_comb begin
        lsu.cmd_ready = gnt_lsu;
        ext.cmd_ready = gnt_ext;
        ram_we        = gnt_any && sel_ok && !sel_read;
        ram_wem       = ram_we ? sel_wmask : '0;
        ram_din       = ram_we ? sel_wdata : '0;
        ram_addr      = (gnt_any && sel_ok) ? sel_idx : addr_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and response outputs toward the owning requester
    always_comb begin
        state_nxt     = state;
        lsu.rsp_valid = 1'b0;
        lsu.rsp_err   = 1'b0;
        lsu.rsp_rdata = '0;
        ext.rsp_valid = 1'b0;
        ext.rsp_err   = 1'b0;
        ext.rsp_rdata = '0;

        if (gnt_lsu) begin
            state_nxt = ST_PEND_L;
        end else if (gnt_ext) begin
            state_nxt = ST_PEND_E;
        end else if (issue_en) begin
            state_nxt = ST_IDLE;
        end

        if (state == ST_PEND_L) begin
            lsu.rsp_valid = 1'b1;
            lsu.rsp_err   = err_q;
            lsu.rsp_rdata = rd_q ? ram_dout : '0;
        end
        if (state == ST_PEND_E) begin
            ext.rsp_valid = 1'b1;
            ext.rsp_err   = err_q;
            ext.rsp_rdata = rd_q ? ram_dout : '0;
        end
    end

    // Capture what kind of response the accepted command owes, and the last RAM index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
        end else if (gnt_any) begin
            rd_q  <= sel_read && sel_ok;
            err_q <= !sel_ok;
            if (sel_ok) begin
                addr_q <= sel_idx;
            end
        end
    end
endmodule

// File: tb/tb_tcm_ctrl.sv
// Bench for tcm_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a word-array reference of the TCM and the
// arbitration rules, plus a behavioural single-port RAM.
module tb_tcm_ctrl;
    localparam int          DP         = 512;
    localparam int          DW         = 32;
    localparam int          MW         = 4;
    localparam int          AW         = 32;
    localparam int          RAW        = 9;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] BASE       = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    always #5 clk = ~clk;

    tcm_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) lsu_if ();
    tcm_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) ext_if ();

    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_din;
    logic [DW-1:0]  ram_dout;
    logic           ram_we;
    logic [MW-1:0]  ram_wem;

    tcm_ctrl #(
        .DP(DP), .DW(DW), .MW(MW), .AW(AW), .RAW(RAW),
        .BASE_ADDR(BASE), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lsu      (lsu_if),
        .ext      (ext_if),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_dout (ram_dout)
    );

    // Behavioural sim_ram: byte-masked write, registered address, 1-cycle read
    logic [DW-1:0]  ram_mem [DP];
    logic [RAW-1:0] ram_addr_r;
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DP; i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            for (int b = 0; b < MW; b++)
                if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_addr_r <= ram_addr;
    end
    assign ram_dout = ram_mem[ram_addr_r];

    // Reference model state
    logic [31:0] ref_mem [DP];
    int          pend;        // 0 nothing owed, 1 owed to LSU, 2 owed to EXT
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          streak;      // LSU grants given while EXT kept asking
    int          last_idx;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DP)
               && (a % 4 == 0);
    endfunction

    task automatic lsu_cmd(input logic v, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wm);
        lsu_if.cmd_valid = v; lsu_if.cmd_read = rd; lsu_if.cmd_addr = a;
        lsu_if.cmd_wdata = wd; lsu_if.cmd_wmask = wm;
    endtask

    task automatic ext_cmd(input logic v, input logic rd, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wm);
        ext_if.cmd_valid = v; ext_if.cmd_read = rd; ext_if.cmd_addr = a;
        ext_if.cmd_wdata = wd; ext_if.cmd_wmask = wm;
    endtask

    // One clock: compare DUT against the model, advance the model, move to next negedge
    task automatic cycle();
        logic        issue, ext_first, g_l, g_e, acc, rd;
        logic [31:0] a, wd;
        logic [3:0]  wm;
        int          idx;
        #1;
        case (pend)
            0:       issue = 1'b1;
            1:       issue = lsu_if.rsp_ready;
            default: issue = ext_if.rsp_ready;
        endcase
        issue     = issue && rst_n;
        ext_first = ext_if.cmd_valid && (!lsu_if.cmd_valid || streak >= STARVE_MAX);
        g_e       = issue && ext_first;
        g_l       = issue && lsu_if.cmd_valid && !ext_first;

        check1("lsu_cmd_ready", lsu_if.cmd_ready, g_l);
        check1("ext_cmd_ready", ext_if.cmd_ready, g_e);
        check1("lsu_rsp_valid", lsu_if.rsp_valid, pend == 1);
        check1("ext_rsp_valid", ext_if.rsp_valid, pend == 2);
        if (pend == 1) begin
            check32("lsu_rsp_rdata", lsu_if.rsp_rdata, exp_rdata);
            check1("lsu_rsp_err", lsu_if.rsp_err, exp_err);
        end else if (pend == 2) begin
            check32("ext_rsp_rdata", ext_if.rsp_rdata, exp_rdata);
            check1("ext_rsp_err", ext_if.rsp_err, exp_err);
        end

        if (g_e) begin
            rd = ext_if.cmd_read; a = ext_if.cmd_addr; wd = ext_if.cmd_wdata; wm = ext_if.cmd_wmask;
        end else begin
            rd = lsu_if.cmd_read; a = lsu_if.cmd_addr; wd = lsu_if.cmd_wdata; wm = lsu_if.cmd_wmask;
        end
        acc = (g_l || g_e) && addr_ok(a);
        idx = int'((a - BASE) / 4);
        check1("ram_we", ram_we, acc && !rd);
        check32("ram_wem", 32'(ram_wem), (acc && !rd) ? 32'(wm) : 32'd0);
        check32("ram_addr", 32'(ram_addr), acc ? 32'(idx) : 32'(last_idx));

        if (!rst_n) begin
            pend = 0; streak = 0; last_idx = 0;
        end else begin
            if (g_l || g_e) begin
                pend      = g_l ? 1 : 2;
                exp_err   = !addr_ok(a);
                exp_rdata = (rd && !exp_err) ? ref_mem[idx] : 32'd0;
                if (!exp_err) begin
                    last_idx = idx;
                    if (!rd)
                        for (int b = 0; b < 4; b++)
                            if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else if (issue) begin
                pend = 0;
            end
            if (g_e || !ext_if.cmd_valid) streak = 0;
            else if (g_l && streak < STARVE_MAX) streak++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return 32'($urandom_range(0, 7) * 4);
        else if (r == 7) return 32'h0000_07FC;
        else if (r == 8) return ($urandom_range(0, 1) == 0) ? 32'h0000_0800 : 32'hFFFF_FFFC;
        else             return 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
    endfunction

    initial begin
        int g, wait_cnt, max_wait;
        for (int i = 0; i < DP; i++) ref_mem[i] = '0;
        pend = 0; streak = 0; last_idx = 0; exp_rdata = '0; exp_err = 1'b0;
        rst_n = 1'b0; clr = 1'b1;
        lsu_cmd(0, 0, 0, 0, 0); ext_cmd(0, 0, 0, 0, 0);
        lsu_if.rsp_ready = 1'b1; ext_if.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Reset with a response pending
        lsu_if.rsp_ready = 1'b0;
        lsu_cmd(1, 1, 32'h10, 0, 0);
        cycle();
        rst_n = 1'b0;
        cycle();
        #1;
        check1("rst_lsu_rsp_valid", lsu_if.rsp_valid, 1'b0);
        check1("rst_lsu_rsp_err", lsu_if.rsp_err, 1'b0);
        check32("rst_lsu_rsp_rdata", lsu_if.rsp_rdata, 32'h0);
        check1("rst_lsu_cmd_ready", lsu_if.cmd_ready, 1'b0);
        check1("rst_ram_we", ram_we, 1'b0);
        check32("rst_ram_wem", 32'(ram_wem), 32'h0);
        check32("rst_ram_addr", 32'(ram_addr), 32'h0);
        rst_n = 1'b1; lsu_if.rsp_ready = 1'b1;
        lsu_cmd(0, 0, 0, 0, 0);
        cycle();
        cycle();

        // Full write then read-back
        lsu_cmd(1, 0, 32'h10, 32'hDEADBEEF, 4'b1111);
        cycle();
        lsu_cmd(1, 1, 32'h10, 0, 0);
        cycle();
        lsu_cmd(0, 0, 0, 0, 0);
        #1;
        check32("rd_after_wr", lsu_if.rsp_rdata, 32'hDEADBEEF);
        check1("rd_after_wr_valid", lsu_if.rsp_valid, 1'b1);
        cycle();

        // Byte-masked write
        lsu_cmd(1, 0, 32'h10, 32'h55667788, 4'b0010);
        cycle();
        lsu_cmd(1, 1, 32'h10, 0, 0);
        cycle();
        lsu_cmd(0, 0, 0, 0, 0);
        #1;
        check32("byte_mask", lsu_if.rsp_rdata, 32'hDEAD77EF);
        cycle();

        // Window edge and error accesses
        lsu_cmd(1, 0, 32'h7FC, 32'hCAFEF00D, 4'b1111);
        cycle();
        lsu_cmd(1, 1, 32'h7FC, 0, 0);
        cycle();
        lsu_cmd(1, 1, 32'h802, 0, 0);
        #1;
        check32("last_word", lsu_if.rsp_rdata, 32'hCAFEF00D);
        cycle();
        lsu_cmd(1, 1, 32'h11, 0, 0);
        #1;
        check1("err_802", lsu_if.rsp_err, 1'b1);
        check32("err_802_rdata", lsu_if.rsp_rdata, 32'h0);
        cycle();
        lsu_cmd(1, 0, 32'h800, 32'h12345678, 4'b1111);
        #1;
        check1("err_011", lsu_if.rsp_err, 1'b1);
        cycle();
        lsu_cmd(0, 0, 0, 0, 0);
        #1;
        check1("err_wr_800", lsu_if.rsp_err, 1'b1);
        cycle();

        // Starvation protection with both requesters always asking
        lsu_cmd(1, 1, 32'h10, 0, 0);
        ext_cmd(1, 1, 32'h20, 0, 0);
        wait_cnt = 0; max_wait = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            g = ext_if.cmd_ready ? 2 : (lsu_if.cmd_ready ? 1 : 0);
            check32($sformatf("starve_grant_%0d", i), 32'(g), (i % 5 == 4) ? 32'd2 : 32'd1);
            wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
            if (g == 2) wait_cnt = 0;
            cycle();
        end
        check1("ext_wait_le5", max_wait <= 5, 1'b1);
        ext_cmd(0, 0, 0, 0, 0);
        lsu_cmd(0, 0, 0, 0, 0);
        cycle();

        // Backpressure on a pending read
        lsu_cmd(1, 1, 32'h10, 0, 0);
        cycle();
        lsu_if.rsp_ready = 1'b0;
        lsu_cmd(1, 1, 32'h14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check32($sformatf("bp_rdata_%0d", i), lsu_if.rsp_rdata, 32'hDEAD77EF);
            check1($sformatf("bp_cmd_ready_%0d", i), lsu_if.cmd_ready, 1'b0);
            cycle();
        end
        lsu_if.rsp_ready = 1'b1;
        cycle();
        lsu_cmd(0, 0, 0, 0, 0);
        cycle();

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            rst_n = !(i == 200 || i == 201);
            lsu_cmd($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rand_addr(),
                    $urandom, 4'($urandom_range(0, 15)));
            ext_cmd($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1, rand_addr(),
                    $urandom, 4'($urandom_range(0, 15)));
            lsu_if.rsp_ready = $urandom_range(0, 3) != 0;
            ext_if.rsp_ready = $urandom_range(0, 3) != 0;
            cycle();
        end

        // Drain
        rst_n = 1'b1;
        lsu_cmd(0, 0, 0, 0, 0); ext_cmd(0, 0, 0, 0, 0);
        lsu_if.rsp_ready = 1'b1; ext_if.rsp_ready = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
